seq_stage_controller: RTL

Multi-cycle sequencer for the sequential Y86-64 processor. Steps one instruction at a time through fetch, decode, execute, memory, write-back and PC-update, one stage per cycle, and stalls in memory on a data-memory handshake. Owns the architectural PC register and selects the next PC value. Tracks the Y86 status code and stops the core on halt or on any fault.

---
 rtl/y86_pkg.sv | 36 +++
 rtl/seq_next_pc.sv | 23 ++
 rtl/seq_stage_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// sequential controller state encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE,
    ST_MEMORY, ST_WRITEBACK, ST_PCUPD, ST_HALT
  } seq_state_t;

  // Instructions that perform a data-memory access in the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == ICODE_RMMOVQ) || (ic == ICODE_MRMOVQ) ||
           (ic == ICODE_CALL)   || (ic == ICODE_RET)    ||
           (ic == ICODE_PUSHQ)  || (ic == ICODE_POPQ);
  endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC select for Y86-64; shared by the sequential and
// pipelined cores.
module seq_next_pc
  import y86_pkg::*;
(
  input  logic [3:0]  i_icode,
  input  logic        i_cnd,
  input  logic [63:0] i_valc,
  input  logic [63:0] i_valm,
  input  logic [63:0] i_valp,
  output logic [63:0] o_next_pc
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_next_pc = i_valp;
    if ((i_icode == ICODE_CALL) || ((i_icode == ICODE_JXX) && i_cnd))
      o_next_pc = i_valc;
    else if (i_icode == ICODE_RET)
      o_next_pc = i_valm;
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: owns the PC and
// the status code. Define SEQ_CTRL_PERF_EN to add cycle/instruction counters.
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [3:0]        icode,
  input  logic [63:0]       valC,
  input  logic [63:0]       valP,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              cnd,
  input  logic [63:0]       valM,
  input  logic              mem_ready,
  input  logic              dmem_error,
  output logic [63:0]       pc,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pc_en,
  output logic              mem_req,
  output logic [2:0]        stat,
  output logic              halted
`ifdef SEQ_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  seq_state_t  r_state, w_state_nxt;
  logic [2:0]  r_stat, w_stat_nxt;
  logic [63:0] r_pc, r_valc, r_valp, r_valm;
  logic [3:0]  r_icode;
  logic        r_cnd;
  logic        w_mem_op, w_mem_done;
  logic [63:0] w_next_pc;

  assign w_mem_op   = is_mem_icode(r_icode);
  assign w_mem_done = !w_mem_op || mem_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    case (r_state)
      ST_IDLE:      if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_error) begin
          w_state_nxt = ST_HALT;
          w_stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          w_state_nxt = ST_HALT;
          w_stat_nxt  = STAT_INS;
        end else if (icode == ICODE_HALT) begin
          w_state_nxt = ST_PCUPD;
        end else begin
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE:    w_state_nxt = ST_EXECUTE;
      ST_EXECUTE:   w_state_nxt = ST_MEMORY;
      ST_MEMORY: begin
        if (w_mem_done) begin
          if (w_mem_op && dmem_error) begin
            w_state_nxt = ST_HALT;
            w_stat_nxt  = STAT_ADR;
          end else begin
            w_state_nxt = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: w_state_nxt = ST_PCUPD;
      ST_PCUPD: begin
        // A halt instruction still retires through PCUPD so pc ends on valP.
        if (r_icode == ICODE_HALT) begin
          w_state_nxt = ST_HALT;
          w_stat_nxt  = STAT_HLT;
        end else if (run) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALT:      w_state_nxt = ST_HALT;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  seq_next_pc u_next_pc (
    .i_icode   (r_icode),
    .i_cnd     (r_cnd),
    .i_valc    (r_valc),
    .i_valm    (r_valm),
    .i_valp    (r_valp),
    .o_next_pc (w_next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_stat  <= STAT_AOK;
      r_pc    <= RESET_PC;
      r_icode <= 4'h0;
      r_valc  <= 64'd0;
      r_valp  <= 64'd0;
      r_valm  <= 64'd0;
      r_cnd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stat  <= w_stat_nxt;
      if (r_state == ST_FETCH) begin
        r_icode <= icode;
        r_valc  <= valC;
        r_valp  <= valP;
      end
      if (r_state == ST_EXECUTE) r_cnd <= cnd;
      if (mem_req && mem_ready)  r_valm <= valM;
      if (r_state == ST_PCUPD)   r_pc <= w_next_pc;
    end
  end

  assign pc        = r_pc;
  assign stat      = r_stat;
  assign halted    = (r_state == ST_HALT);
  assign fetch_en  = (r_state == ST_FETCH);
  assign decode_en = (r_state == ST_DECODE);
  assign exec_en   = (r_state == ST_EXECUTE);
  assign mem_en    = (r_state == ST_MEMORY);
  assign wb_en     = (r_state == ST_WRITEBACK);
  assign pc_en     = (r_state == ST_PCUPD);
  assign mem_req   = (r_state == ST_MEMORY) && w_mem_op;

`ifdef SEQ_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_HALT) && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if ((r_state == ST_PCUPD) && (r_instr_cnt != '1))
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
